// File: rtl/shift_out_pkg.sv
// rtl/shift_out_pkg.sv - shared states and default sizing for the shift-out controller
package shift_out_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int SHIFT_OUT_WIDTH   = 8;
  localparam int SHIFT_OUT_CLK_DIV = 6;

endpackage

// File: rtl/shift_out_phase_timer.sv
// rtl/shift_out_phase_timer.sv - phase divider, strobes every CLK_DIV cycles, restartable
module shift_out_phase_timer
  import shift_out_pkg::*;
#(
  parameter int CLK_DIV = SHIFT_OUT_CLK_DIV
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic strobe
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // Strobe on the terminal count so every phase lasts exactly CLK_DIV cycles.
  assign strobe = (count_q == TERM);

  // Count up, wrapping on the terminal count or when the controller enters a new state.
  always_comb begin
    count_d = count_q + CW'(1);
    if (restart || strobe) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_out_controller.sv
// rtl/shift_out_controller.sv - 74HC595-style shift/latch sequencer; SHIFT_OUT_CONTROLLER_OE_EN adds oe_n
module shift_out_controller
  import shift_out_pkg::*;
#(
  parameter int WIDTH   = SHIFT_OUT_WIDTH,
  parameter int CLK_DIV = SHIFT_OUT_CLK_DIV
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             busy,
  output logic             sr_data,
  output logic             sr_clock,
  output logic             sr_latch
`ifdef SHIFT_OUT_CONTROLLER_OE_EN
  ,
  output logic             oe_n
`endif
);

  // A single-bit counter is kept even for WIDTH=1 so the port widths stay legal.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             sr_data_q, sr_data_d;
  logic             sr_clock_q, sr_clock_d;
  logic             sr_latch_q, sr_latch_d;
  logic             strobe;
  logic             restart;

  // Every state change restarts the phase so each state gets a full CLK_DIV cycles.
  assign restart = (state_d != state_q);

  shift_out_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .strobe  (strobe)
  );

  // Next state: accept in IDLE, then SETUP/HIGH per bit MSB first, then one LATCH phase.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shadow_d  = data;
          bit_cnt_d = LAST_BIT;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (strobe) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (strobe) begin
          if (bit_cnt_q != '0) begin
            shadow_d  = shadow_q << 1;
            bit_cnt_d = bit_cnt_q - BW'(1);
            state_d   = SETUP;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (strobe) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins change on the same edge as the state.
  always_comb begin
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    sr_clock_d = (state_d == HIGH);
    sr_latch_d = (state_d == LATCH);
    sr_data_d  = 1'b0;
    case (state_d)
      SETUP:   sr_data_d = shadow_d[WIDTH-1];
      HIGH:    sr_data_d = sr_data_q;
      default: sr_data_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      bit_cnt_q  <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_clock_q <= 1'b0;
      sr_latch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      sr_data_q  <= sr_data_d;
      sr_clock_q <= sr_clock_d;
      sr_latch_q <= sr_latch_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign sr_data  = sr_data_q;
  assign sr_clock = sr_clock_q;
  assign sr_latch = sr_latch_q;

`ifdef SHIFT_OUT_CONTROLLER_OE_EN
  logic oe_n_q, oe_n_d;

  // Keep the LEDs blanked until the first complete word has been latched.
  always_comb begin
    oe_n_d = oe_n_q;
    if (state_q == LATCH && state_d == IDLE) begin
      oe_n_d = 1'b0;
    end
  end

  // Output-enable register; only reset can blank the LEDs again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_n_q <= 1'b1;
    end else begin
      oe_n_q <= oe_n_d;
    end
  end

  assign oe_n = oe_n_q;
`endif

endmodule
